// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM port-0 arbiter: FSM states and the March C-
// element table, stored as per-element flag vectors (bit i describes element i).
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WINIT,
    ST_RD,
    ST_CMP,
    ST_WR,
    ST_DONE
  } state_t;

  localparam int NUM_ELEMS = 6;

  // Elements: 0 up w0 | 1 up r0,w1 | 2 up r1,w0 | 3 down r0,w1 | 4 down r1,w0 | 5 up r0
  // ("0" = background, "1" = inverted background). Bits 6-7 pad the 3-bit index.
  localparam logic [7:0] ELEM_DESC   = 8'b0001_1000;
  localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;
  localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;

endpackage

// File: rtl/sram_port_mux.sv
// Selects who drives SRAM port 0: the host while the BIST is idle, the BIST
// engine otherwise. Host chip-select cannot leak through while BIST owns the port.
module sram_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              bist_own,
  input  logic              bist_csb,
  input  logic              bist_web,
  input  logic [ADDR_W-1:0] bist_addr,
  input  logic [DATA_W-1:0] bist_din,
  input  logic              host_csb,
  input  logic              host_web,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0
);

  assign csb0   = bist_own ? bist_csb  : host_csb;
  assign web0   = bist_own ? bist_web  : host_web;
  assign addr0  = bist_own ? bist_addr : host_addr;
  assign din0   = bist_own ? bist_din  : host_din;
  assign wmask0 = 4'b1111;

endmodule

// File: rtl/sram_bist_arbiter.sv
// SRAM port-0 arbiter: host passthrough when idle, March C- self-test on start,
// reporting pass/fail and the first failing address, element and read data.
module sram_bist_arbiter
  import sram_pkg::*;
#(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              bist_start,
  input  logic              bist_abort,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  input  logic              host_csb0,
  input  logic              host_web0,
  input  logic [ADDR_W-1:0] host_addr0,
  input  logic [DATA_W-1:0] host_din0,
  output logic              host_stall,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0
);

  localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAST_ELEM = 3'(NUM_ELEMS - 1);

  state_t            state;
  logic [2:0]        elem;
  logic [ADDR_W-1:0] addr;

  logic [2:0]        nxt_elem;
  logic [ADDR_W-1:0] nxt_start;
  logic [ADDR_W-1:0] addr_step;
  logic              addr_last;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] wr_data;
  logic              mismatch;

  logic              bist_own;
  logic              bist_csb;
  logic              bist_web;

  // Address sequencing compares against the explicit end points so a DEPTH
  // smaller than the address space never walks into untested words.
  always_comb begin
    nxt_elem  = elem + 3'd1;
    nxt_start = ELEM_DESC[nxt_elem] ? ADDR_TOP : '0;
    addr_last = ELEM_DESC[elem] ? (addr == '0) : (addr == ADDR_TOP);
    addr_step = ELEM_DESC[elem] ? addr - 1'b1 : addr + 1'b1;
    exp_data  = ELEM_RD_INV[elem] ? ~BG : BG;
    wr_data   = ELEM_WR_INV[elem] ? ~BG : BG;
    mismatch  = ELEM_HAS_RD[elem] && (dout0 != exp_data);
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    bist_own = (state != ST_IDLE) && (state != ST_DONE);
    bist_csb = 1'b1;
    bist_web = 1'b1;
    unique case (state)
      ST_WINIT, ST_WR: begin
        bist_csb = 1'b0;
        bist_web = 1'b0;
      end
      ST_RD:   bist_csb = 1'b0;
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      elem      <= '0;
      addr      <= '0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
    end else begin
      bist_done <= 1'b0;
      if (bist_abort && bist_busy) begin
        state     <= ST_IDLE;
        bist_busy <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (bist_start) begin
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            elem      <= '0;
            addr      <= '0;
            bist_busy <= 1'b1;
            state     <= ST_WINIT;
          end
          ST_WINIT: begin
            if (!addr_last) begin
              addr <= addr_step;
            end else begin
              elem  <= nxt_elem;
              addr  <= nxt_start;
              state <= ST_RD;
            end
          end
          ST_RD: state <= ST_CMP;
          ST_CMP: begin
            if (mismatch) begin
              bist_fail <= 1'b1;
              fail_addr <= addr;
              fail_elem <= elem;
              fail_data <= dout0;
              bist_busy <= 1'b0;
              bist_done <= 1'b1;
              state     <= ST_DONE;
            end else if (ELEM_HAS_WR[elem]) begin
              state <= ST_WR;
            end else if (!addr_last) begin
              addr  <= addr_step;
              state <= ST_RD;
            end else if (elem == LAST_ELEM) begin
              bist_busy <= 1'b0;
              bist_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              elem  <= nxt_elem;
              addr  <= nxt_start;
              state <= ST_RD;
            end
          end
          ST_WR: begin
            state <= ST_RD;
            if (!addr_last) begin
              addr <= addr_step;
            end else begin
              elem <= nxt_elem;
              addr <= nxt_start;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign host_stall = bist_busy;

  sram_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_port_mux (
    .bist_own (bist_own),
    .bist_csb (bist_csb),
    .bist_web (bist_web),
    .bist_addr(addr),
    .bist_din (wr_data),
    .host_csb (host_csb0),
    .host_web (host_web0),
    .host_addr(host_addr0),
    .host_din (host_din0),
    .csb0     (csb0),
    .web0     (web0),
    .wmask0   (wmask0),
    .addr0    (addr0),
    .din0     (din0)
  );

endmodule

// File: tb/tb_sram_bist_arbiter.sv
// Bench for sram_bist_arbiter: behavioural SRAM with an optional stuck-at bit,
// and a March C- reference written as plain element/address loops.
module tb_sram_bist_arbiter;

  localparam int          ADDR_W = 8;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BG     = 32'h0000_0000;

  logic              clk;
  logic              wb_rst_i;
  logic              bist_start, bist_abort;
  logic              bist_busy, bist_done, bist_fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_data;
  logic              host_csb0, host_web0;
  logic [ADDR_W-1:0] host_addr0;
  logic [DATA_W-1:0] host_din0;
  logic              host_stall;
  logic              csb0, web0;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0, dout0;

  int n_checks = 0;
  int n_pass   = 0;

  sram_bist_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BG(BG)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .bist_start(bist_start), .bist_abort(bist_abort),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_data(fail_data),
    .host_csb0(host_csb0), .host_web0(host_web0),
    .host_addr0(host_addr0), .host_din0(host_din0), .host_stall(host_stall),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Behavioural SRAM; a stuck-at cell corrupts one bit on every write to it.
  logic [31:0] mem [256];
  bit          fault_en = 0;
  int          fault_addr, fault_bit;
  bit          fault_val;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        logic [31:0] d;
        d = din0;
        if (fault_en && int'(addr0) == fault_addr) d[fault_bit] = fault_val;
        mem[addr0] <= d;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  // Port-ownership monitor, enabled while the host hammers the port mid-test.
  bit intrude = 0;
  int bad_stall, csb_low, wr_cycles, leak;

  always @(negedge clk) begin
    if (intrude && bist_busy) begin
      if (!host_stall) bad_stall++;
      if (!csb0) begin
        csb_low++;
        if (!web0) begin
          wr_cycles++;
          if (din0 == host_din0) leak++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // March C- reference: returns busy-cycle count (write = 1 cycle, read+compare
  // = 2 cycles) and the first mismatch, if any.
  task automatic ref_march(input bit f_en, input int f_a, input int f_b, input bit f_v,
                           output int cyc, output bit fl, output int fa,
                           output int fe, output logic [31:0] fd);
    logic [31:0] m [DEPTH];
    int rd_of [6] = '{-1, 0, 1, 0, 1, 0};   // -1 none, 0 BG, 1 ~BG
    int wr_of [6] = '{0, 1, 0, 1, 0, -1};
    int down  [6] = '{0, 0, 0, 1, 1, 0};
    cyc = 0; fl = 0; fa = 0; fe = 0; fd = '0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        int a;
        a = down[e] ? DEPTH - 1 - k : k;
        if (rd_of[e] >= 0) begin
          logic [31:0] expv;
          cyc += 2;
          expv = rd_of[e] ? ~BG : BG;
          if (m[a] !== expv) begin
            fl = 1; fa = a; fe = e; fd = m[a];
            return;
          end
        end
        if (wr_of[e] >= 0) begin
          logic [31:0] w;
          cyc += 1;
          w = wr_of[e] ? ~BG : BG;
          if (f_en && a == f_a) w[f_b] = f_v;
          m[a] = w;
        end
      end
    end
  endtask

  task automatic pass_check(input logic cs, input logic we, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    host_csb0 = cs; host_web0 = we; host_addr0 = a; host_din0 = d;
    #1;
    check("pass_csb",   csb0,       cs);
    check("pass_web",   web0,       we);
    check("pass_addr",  addr0,      a);
    check("pass_din",   din0,       d);
    check("pass_wmask", wmask0,     4'b1111);
    check("pass_stall", host_stall, 1'b0);
  endtask

  task automatic start_pulse();
    @(negedge clk); bist_start = 1'b1;
    @(negedge clk); bist_start = 1'b0;
  endtask

  task automatic do_run(input string tag, input bit f_en, input int f_a, input int f_b, input bit f_v);
    int cyc, fa, fe, cnt;
    bit fl;
    logic [31:0] fd;
    fault_en = f_en; fault_addr = f_a; fault_bit = f_b; fault_val = f_v;
    ref_march(f_en, f_a, f_b, f_v, cyc, fl, fa, fe, fd);
    start_pulse();
    cnt = 0;
    while (bist_busy && cnt < 20 * DEPTH) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cnt, cyc);
    check({tag, "_done"},        bist_done, 1'b1);
    check({tag, "_fail"},        bist_fail, fl);
    check({tag, "_fail_addr"},   fail_addr, fa);
    check({tag, "_fail_elem"},   fail_elem, fe);
    check({tag, "_fail_data"},   fail_data, fd);
    @(negedge clk);
    check({tag, "_done_1cyc"},   bist_done, 1'b0);
    fault_en = 0;
  endtask

  initial begin
    int dcount;
    wb_rst_i = 1'b1; bist_start = 1'b0; bist_abort = 1'b0;
    host_csb0 = 1'b1; host_web0 = 1'b1; host_addr0 = '0; host_din0 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  bist_busy,  1'b0);
    check("rst_done",  bist_done,  1'b0);
    check("rst_fail",  bist_fail,  1'b0);
    check("rst_faddr", fail_addr,  '0);
    check("rst_felem", fail_elem,  '0);
    check("rst_fdata", fail_data,  '0);
    check("rst_stall", host_stall, 1'b0);
    wb_rst_i = 1'b0;

    pass_check(1'b0, 1'b0, 8'd5, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++)
      pass_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), $urandom);

    // Clean run while the host keeps trying to write through the port.
    @(negedge clk);
    host_csb0 = 1'b0; host_web0 = 1'b0; host_addr0 = 8'd3; host_din0 = 32'h5A5A_1234;
    bad_stall = 0; csb_low = 0; wr_cycles = 0; leak = 0;
    intrude = 1;
    do_run("clean", 0, 0, 0, 0);
    intrude = 0;
    host_csb0 = 1'b1; host_web0 = 1'b1;
    check("intr_stall",   bad_stall, 0);
    check("intr_csb_low", csb_low,   10 * DEPTH);
    check("intr_writes",  wr_cycles, 5 * DEPTH);
    check("intr_leak",    leak,      0);

    do_run("stuck9b3", 1, 9, 3, 1);

    @(negedge clk); wb_rst_i = 1'b1;
    @(negedge clk); wb_rst_i = 1'b0;
    check("idle_rst_fail",  bist_fail, 1'b0);
    check("idle_rst_faddr", fail_addr, '0);
    check("idle_rst_fdata", fail_data, '0);

    for (int i = 0; i < 3; i++)
      do_run("rand_fault", 1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 31),
             1'($urandom_range(0, 1)));

    // Abort 50 cycles into a run.
    start_pulse();
    repeat (49) @(negedge clk);
    bist_abort = 1'b1;
    @(negedge clk);
    bist_abort = 1'b0;
    check("abort_busy", bist_busy, 1'b0);
    check("abort_csb",  csb0,      1'b1);
    check("abort_done", bist_done, 1'b0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bist_done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    pass_check(1'b0, 1'b1, 8'd7, 32'h1357_9BDF);
    host_csb0 = 1'b1;
    do_run("post_abort", 0, 0, 0, 0);

    // Reset 100 cycles into a run.
    start_pulse();
    repeat (99) @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  bist_busy,  1'b0);
    check("mid_rst_done",  bist_done,  1'b0);
    check("mid_rst_fail",  bist_fail,  1'b0);
    check("mid_rst_stall", host_stall, 1'b0);
    check("mid_rst_csb",   csb0,       1'b1);
    wb_rst_i = 1'b0;
    do_run("post_reset", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_bist_arbiter.md
Name: sram_bist_arbiter

Overview:
Owns SRAM port 0 (read/write) of the user-project macro.
- Idle: passes Wishbone-derived host requests straight through to the macro.
- On start: takes the port and runs a March C- self-test over every address, then reports pass/fail and the first failing location.
- Sits between the Wishbone slave decode and the SRAM macro pins.

Parameters:
ADDR_W, 8, SRAM word-address width
DATA_W, 32, SRAM data width
DEPTH, 256, words tested (must be <= 2**ADDR_W)
BG, 32'h00000000, data background; inverse is ~BG

Ports:
wb_clk_i  in  1  clock; also drives the SRAM clock pin
wb_rst_i  in  1  synchronous active-high reset
bist_start  in  1  single-cycle pulse; starts a test (ignored unless IDLE)
bist_abort  in  1  synchronous abort; returns to IDLE
bist_busy  out  1  test running; port 0 owned by BIST
bist_done  out  1  one-cycle pulse at test completion or fail-abort
bist_fail  out  1  sticky mismatch flag; cleared on the next accepted start
fail_addr  out  ADDR_W  address of the first mismatch
fail_elem  out  3  March element index (0-5) of the first mismatch
fail_data  out  DATA_W  dout0 value at the first mismatch
host_csb0  in  1  host chip-select, active-low
host_web0  in  1  host write-enable, active-low
host_addr0  in  ADDR_W  host address
host_din0  in  DATA_W  host write data
host_stall  out  1  equals bist_busy; host must not issue while high
csb0  out  1  to SRAM
web0  out  1  to SRAM
wmask0  out  4  to SRAM; always 4'b1111
addr0  out  ADDR_W  to SRAM
din0  out  DATA_W  to SRAM
dout0  in  DATA_W  from SRAM; valid the cycle after a read is issued

Behaviour:
- Reset: state IDLE; bist_busy=0, bist_done=0, bist_fail=0, fail_addr/elem/data=0, address counter=0.
- Mux (combinational):
  - IDLE/DONE: SRAM pins = host pins.
  - Otherwise: pins driven by FSM. Host csb0 is blocked (csb0=1 unless FSM drives it).
- States: IDLE, WINIT, RD, CMP, WR, DONE.
- IDLE: bist_start -> clear bist_fail/fail_*; load element 0, addr=0; go WINIT. bist_busy rises the next cycle.
- Elements:
  - 0 ascending w(BG)
  - 1 ascending r(BG),w(~BG)
  - 2 ascending r(~BG),w(BG)
  - 3 descending r(BG),w(~BG)
  - 4 descending r(~BG),w(BG)
  - 5 ascending r(BG)
  - Ascending runs 0..DEPTH-1; descending runs DEPTH-1..0.
- WINIT: csb0=0, web0=0, din0=BG for one cycle per address. Last address -> element 1, addr=0, go RD.
- RD: csb0=0, web0=1, addr0=addr. Go CMP.
- CMP: csb0=1; compare dout0 with expected.
  - Mismatch: latch fail_addr=addr, fail_elem, fail_data=dout0; set bist_fail; go DONE.
  - Match: go WR for elements 1-4. For element 5, advance the address, or go DONE after the last address.
- WR: csb0=0, web0=0, din0=element write value. Then advance the address, or at element end load the next element's start address and go RD.
- DONE: bist_done=1 for exactly one cycle, bist_busy=0; go IDLE.
- Cycle counts:
  - Passing run: 15*DEPTH cycles with bist_busy high (DEPTH + 4*3*DEPTH + 2*DEPTH).
  - bist_done high in the following cycle.
- Address wrap: counter compare uses DEPTH-1 and 0 explicitly. Never wraps past DEPTH-1 when DEPTH < 2**ADDR_W.
- bist_abort in any busy state: go IDLE next cycle; csb0 deasserted in that cycle. No bist_done pulse; bist_fail unchanged. bist_abort has priority over bist_start.
- bist_start while busy: ignored.
- Reset mid-test: all outputs to reset values next edge; SRAM contents undefined.

Decomposition:
- Shared package sram_pkg:
  - State enum.
  - March element table constants: direction, read-expected, write-value select, has-read, has-write.
  - Element-count constant (6).
- One sub-module, sram_port_mux: combinational host/BIST mux for csb0/web0/addr0/din0/wmask0.

Test Plan:
- Idle passthrough: host_csb0=0, host_web0=0, host_addr0=5, host_din0=32'hA5A5A5A5 -> csb0=0, web0=0, addr0=5, din0=32'hA5A5A5A5 same cycle; host_stall=0.
- Clean run, DEPTH=16 behavioural SRAM: start pulse -> bist_busy high exactly 240 cycles; bist_done pulse; bist_fail=0.
- Stuck-at fault: SRAM model forces bit 3 of address 9 to 1 -> bist_fail=1, fail_elem=1, fail_addr=9, fail_data=32'h00000008; bist_done pulses right after that CMP.
- Abort at cycle 50: bist_abort pulse -> bist_busy=0 and csb0=1 next cycle, no bist_done; host passthrough restored; a new start runs full length.
- Host request during BIST: host_csb0=0 while busy -> csb0 follows FSM only, host_stall=1, host data never reaches din0.
- Reset at cycle 100: wb_rst_i pulse -> all outputs zero next edge, state IDLE; a following start passes with bist_fail=0.
